// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-outstanding issue controller between the integer
// pipeline and a multi-cycle FPU. It accepts one FP request and drives the
// operands and a one-cycle start pulse. It then waits for completion and
// writes the result back to the register file (rd = 0 is never written).
// Optional feature macro: FPU_ISSUE_TIMEOUT_EN -- when defined, an 8-bit
// WAIT counter aborts an operation after TIMEOUT_CYCLES cycles without
// fpu_done. It reports the abort on err for one cycle, via the ERR state.
module fpu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        req_ready,
  output logic [31:0] fpu_A,
  output logic [31:0] fpu_B,
  output logic [1:0]  fpu_op,
  output logic        fpu_start,
  input  logic        fpu_done,
  input  logic [31:0] fpu_R,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        err
);

  // The counter is only 8 bits wide, so limits outside 1..255 cannot work.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("fpu_issue_ctrl: TIMEOUT_CYCLES must be within 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3
`ifdef FPU_ISSUE_TIMEOUT_EN
    , S_ERR = 3'd4
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;

  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;
  logic        fpu_start_q, fpu_start_d;
  logic [31:0] fpu_a_q, fpu_a_d;
  logic [31:0] fpu_b_q, fpu_b_d;
  logic [1:0]  fpu_op_q, fpu_op_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        err_q, err_d;

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;
`endif

  // Next-state and next-output logic; every output is a flop decoded from
  // the next state so the pipeline sees glitch-free, registered signals.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    res_d   = res_q;
`ifdef FPU_ISSUE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          op_d    = req_op;
          rd_d    = req_rd;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The start pulse lasts exactly this one cycle.
        state_d = S_WAIT;
`ifdef FPU_ISSUE_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      S_WAIT: begin
        // A done on the limit cycle still counts as success.
        if (fpu_done) begin
          res_d   = fpu_R;
          state_d = S_WB;
        end
`ifdef FPU_ISSUE_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_LIM) begin
            state_d = S_ERR;
          end
        end
`endif
      end
      S_WB: begin
        state_d = S_IDLE;
      end
`ifdef FPU_ISSUE_TIMEOUT_EN
      S_ERR: begin
        state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    fpu_start_d = (state_d == S_ISSUE);
    if (state_d == S_ISSUE || state_d == S_WAIT) begin
      fpu_a_d  = a_d;
      fpu_b_d  = b_d;
      fpu_op_d = op_d;
    end else begin
      fpu_a_d  = 32'd0;
      fpu_b_d  = 32'd0;
      fpu_op_d = 2'd0;
    end
    // x0 is hard-wired zero, so its writeback strobe is suppressed.
    // Data and rd are still shown and then held until the next writeback.
    wb_valid_d = (state_d == S_WB) && (rd_d != 5'd0);
    wb_rd_d    = (state_d == S_WB) ? rd_d  : wb_rd_q;
    wb_data_d  = (state_d == S_WB) ? res_d : wb_data_q;
`ifdef FPU_ISSUE_TIMEOUT_EN
    err_d      = (state_d == S_ERR);
`else
    err_d      = 1'b0;
`endif
  end

  // State and output registers; reset wins over any request or completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      op_q        <= 2'd0;
      rd_q        <= 5'd0;
      res_q       <= 32'd0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      fpu_start_q <= 1'b0;
      fpu_a_q     <= 32'd0;
      fpu_b_q     <= 32'd0;
      fpu_op_q    <= 2'd0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
      err_q       <= 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      res_q       <= res_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      fpu_start_q <= fpu_start_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      fpu_op_q    <= fpu_op_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
`ifdef FPU_ISSUE_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign fpu_start = fpu_start_q;
  assign fpu_A     = fpu_a_q;
  assign fpu_B     = fpu_b_q;
  assign fpu_op    = fpu_op_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed and randomized transactions for fpu_issue_ctrl.
// Expected behaviour comes from the transaction timing rules:
// - accept at N, start at N+1, done seen at M, writeback at M+1, ready at M+2.
// - the bench remembers the last writeback rd/data, which hold between writebacks.
module tb_fpu_issue_ctrl;

  localparam int TMO = 4;
`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int MAXD   = TMO - 1;  // latest WAIT index where done still wins
  localparam int BASICD = TMO - 1;
  localparam int RST_AT = 2;
`else
  localparam int MAXD   = 12;
  localparam int BASICD = 9;        // done 10 cycles after the start pulse
  localparam int RST_AT = 4;        // fifth WAIT cycle
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;
  logic        req_ready;
  logic [31:0] fpu_A, fpu_B;
  logic [1:0]  fpu_op;
  logic        fpu_start;
  logic        fpu_done;
  logic [31:0] fpu_R;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy, err;

  int checks = 0;
  int errors = 0;

  // Reference state: last writeback seen on the register-file port.
  logic [4:0]  last_rd;
  logic [31:0] last_data;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_rd(req_rd), .req_ready(req_ready),
    .fpu_A(fpu_A), .fpu_B(fpu_B), .fpu_op(fpu_op), .fpu_start(fpu_start),
    .fpu_done(fpu_done), .fpu_R(fpu_R),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ready"},   req_ready, 1);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_start"},   fpu_start, 0);
    chk({tag, "_A"},       fpu_A, 0);
    chk({tag, "_B"},       fpu_B, 0);
    chk({tag, "_op"},      fpu_op, 0);
    chk({tag, "_wbvalid"}, wb_valid, 0);
    chk({tag, "_wbrd"},    wb_rd, 0);
    chk({tag, "_wbdata"},  wb_data, 0);
    chk({tag, "_err"},     err, 0);
  endtask

  // One complete operation, starting with the controller idle.
  // dly = number of WAIT cycles before the done cycle.
  // hold = leave req_valid high for the following request.
  // spur = fpu_done is also high during the accept and ISSUE cycles.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [4:0] rd, input int dly,
                       input logic [31:0] r, input logic hold, input logic spur);
    chk({tag, "_pre_ready"}, req_ready, 1);
    chk({tag, "_pre_wbdata"}, wb_data, last_data);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_rd = rd;
    if (spur) begin
      fpu_done = 1'b1;
      fpu_R = 32'hDEAD_BEEF;
    end
    step();                              // accepted -> ISSUE
    if (!hold) req_valid = 1'b0;
    chk({tag, "_start"}, fpu_start, 1);
    chk({tag, "_A"}, fpu_A, a);
    chk({tag, "_B"}, fpu_B, b);
    chk({tag, "_op"}, fpu_op, 32'(op));
    chk({tag, "_ready_issue"}, req_ready, 0);
    chk({tag, "_busy_issue"}, busy, 1);
    step();                              // WAIT index 0
    fpu_done = 1'b0;
    for (int k = 0; k <= dly; k++) begin
      chk({tag, "_start_once"}, fpu_start, 0);
      chk({tag, "_A_wait"}, fpu_A, a);
      chk({tag, "_wbvalid_wait"}, wb_valid, 0);
      chk({tag, "_err_wait"}, err, 0);
      if (k == dly) begin
        fpu_done = 1'b1;
        fpu_R = r;
      end
      step();
    end
    fpu_done = 1'b0;
    fpu_R = $urandom();
    last_rd = rd;
    last_data = r;
    $display("txn %s a=%h b=%h op=%0d rd=%0d wait=%0d R=%h hold=%0b spur=%0b",
             tag, a, b, op, rd, dly, r, hold, spur);
    chk({tag, "_wbvalid"}, wb_valid, (rd != 5'd0) ? 1 : 0);
    chk({tag, "_wbrd"}, wb_rd, 32'(last_rd));
    chk({tag, "_wbdata"}, wb_data, last_data);
    chk({tag, "_busy_wb"}, busy, 1);
    chk({tag, "_ready_wb"}, req_ready, 0);
    chk({tag, "_A_wb"}, fpu_A, 0);
    step();                              // back to IDLE
    chk({tag, "_wbvalid_end"}, wb_valid, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_ready_end"}, req_ready, 1);
    chk({tag, "_wbrd_hold"}, wb_rd, 32'(last_rd));
    chk({tag, "_wbdata_hold"}, wb_data, last_data);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_a = 32'd0; req_b = 32'd0;
    req_rd = 5'd0; fpu_done = 1'b0; fpu_R = 32'd0;
    last_rd = 5'd0; last_data = 32'd0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk_reset_values("reset");

    // Basic operation
    do_op("basic", 32'h3F80_0000, 32'h4000_0000, 2'd0, 5'd5, BASICD,
          32'h4040_0000, 1'b0, 1'b0);

    // Spurious done while idle
    fpu_done = 1'b1;
    fpu_R = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("spur_idle_wbvalid", wb_valid, 0);
      chk("spur_idle_busy", busy, 0);
      chk("spur_idle_wbdata", wb_data, last_data);
    end
    fpu_done = 1'b0;

    // Spurious done through accept and ISSUE
    do_op("spur_issue", 32'h4120_0000, 32'h3F00_0000, 2'd2, 5'd7, 1,
          32'h40A0_0000, 1'b0, 1'b1);

    // rd = 0 completes with unchanged timing
    do_op("rd0", 32'h1, 32'h2, 2'd1, 5'd0, 2, 32'h3F80_0000, 1'b0, 1'b0);

    // Back-to-back requests while req_valid is held
    do_op("b2b_1", 32'hAAAA_0001, 32'h5555_0001, 2'd3, 5'd9, 1,
          32'h0BAD_F00D, 1'b1, 1'b0);
    do_op("b2b_2", 32'hAAAA_0002, 32'h5555_0002, 2'd1, 5'd10, 0,
          32'hC0DE_0002, 1'b0, 1'b0);

    // Reset in the middle of WAIT, with done asserted in the same cycle
    req_valid = 1'b1; req_a = 32'h7777_7777; req_b = 32'h8888_8888;
    req_op = 2'd2; req_rd = 5'd12;
    step();
    req_valid = 1'b0;
    for (int k = 0; k <= RST_AT; k++) step();
    rst = 1'b1;
    fpu_done = 1'b1;
    fpu_R = 32'hFFFF_0000;
    step();
    rst = 1'b0;
    last_rd = 5'd0;
    last_data = 32'd0;
    chk_reset_values("rst_wait");
    step();
    chk("rst_wait_done_ignored", wb_valid, 0);
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_ready", req_ready, 1);
    fpu_done = 1'b0;

    // No completion ever arrives
    req_valid = 1'b1; req_a = 32'h0F0F_0F0F; req_b = 32'hF0F0_F0F0;
    req_op = 2'd1; req_rd = 5'd3;
    step();
    req_valid = 1'b0;
    chk("tmo_start", fpu_start, 1);
`ifdef FPU_ISSUE_TIMEOUT_EN
    for (int k = 0; k < TMO; k++) begin
      step();
      chk("tmo_wait_err", err, 0);
      chk("tmo_wait_busy", busy, 1);
    end
    step();
    chk("tmo_err_pulse", err, 1);
    chk("tmo_err_wbvalid", wb_valid, 0);
    chk("tmo_err_busy", busy, 1);
    chk("tmo_err_wbdata", wb_data, last_data);
    step();
    chk("tmo_end_err", err, 0);
    chk("tmo_end_ready", req_ready, 1);
    chk("tmo_end_busy", busy, 0);
    $display("txn timeout err_pulse_after=%0d", TMO);
`else
    for (int k = 0; k < 20; k++) begin
      step();
      chk("notmo_busy", busy, 1);
      chk("notmo_err", err, 0);
      chk("notmo_wbvalid", wb_valid, 0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_rd = 5'd0;
    last_data = 32'd0;
    chk_reset_values("notmo_rst");
    $display("txn no_timeout busy_held=20");
`endif

    // Randomized operations
    for (int i = 0; i < 12; i++) begin
      logic [4:0] rd;
      logic       hold;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      hold = (i < 11) && ($urandom_range(0, 1) == 1);
      do_op("rand", $urandom(), $urandom(), 2'($urandom_range(0, 3)), rd,
            $urandom_range(0, MAXD), $urandom(), hold,
            $urandom_range(0, 1) == 1);
    end
    req_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
